// File: rtl/node_burst_reader_pkg.sv
// Shared constants for the node burst reader: burst geometry, node word
// width and the FSM state encoding.
package node_burst_reader_pkg;

    localparam int BURST_LEN = 32;   // 16-bit beats per node word
    localparam int BEAT_W    = 16;   // width of one read beat
    localparam int NODE_W    = 512;  // assembled node word width
    localparam int CNT_W     = 6;    // beat counter / burstcount width
    localparam int ALIGN_W   = 6;    // node words are 64-byte aligned

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RECV = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/node_burst_reader.sv
// Node burst reader: accepts a byte address, issues one Avalon-MM burst
// read of a 64-byte aligned node word, assembles the 16-bit beats into a
// 512-bit word and presents it on a valid/ready stream. One burst is in
// flight at a time; beats arriving outside a receive window are dropped
// and flagged on the sticky stray_beat output.
module node_burst_reader #(
    parameter int BURST_LEN = node_burst_reader_pkg::BURST_LEN,
    parameter int ADDR_W    = 26
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [ADDR_W-1:0]                     asi_addr_data,
    input  logic                                  asi_addr_valid,
    output logic                                  asi_addr_ready,
    output logic [ADDR_W-1:0]                     avm_node_address,
    output logic                                  avm_node_read,
    output logic [5:0]                            avm_node_burstcount,
    input  logic                                  avm_node_waitrequest,
    input  logic [15:0]                           avm_node_readdata,
    input  logic                                  avm_node_readdatavalid,
    output logic [node_burst_reader_pkg::NODE_W-1:0] aso_node_data,
    output logic                                  aso_node_valid,
    input  logic                                  aso_node_ready,
    output logic                                  busy,
    output logic                                  stray_beat
);

    import node_burst_reader_pkg::*;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << ALIGN_W) - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   beat_cnt;
    logic [NODE_W-1:0]  node_word;
    logic               accept;
    logic               beat_take;
    logic               beat_last;

    // A beat is consumed while receiving, and also in the very cycle the
    // read command is accepted (a slave may return data that early).
    always_comb begin
        accept    = (state == ST_IDLE) && asi_addr_valid;
        beat_take = avm_node_readdatavalid &&
                    ((state == ST_RECV) ||
                     ((state == ST_REQ) && !avm_node_waitrequest));
        beat_last = (beat_cnt == LAST_BEAT);
    end

    // Next-state decode for the request/receive/output sequence.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (asi_addr_valid) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!avm_node_waitrequest) begin
                    state_next = (beat_take && beat_last) ? ST_OUT : ST_RECV;
                end
            end
            ST_RECV: begin
                if (beat_take && beat_last) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (aso_node_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the aligned request address; it stays stable through the burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
        end else if (accept) begin
            addr <= asi_addr_data & ALIGN_MASK;
        end
    end

    // Beat counter advances only on accepted beats and restarts per burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= '0;
        end else if (beat_take) begin
            beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
        end
    end

    // Indexed beat assembly; the word is untouched once in OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            node_word <= '0;
        end else if (beat_take) begin
            node_word[BEAT_W*beat_cnt +: BEAT_W] <= avm_node_readdata;
        end
    end

    // Sticky flag for beats that arrive with no receive window open.
    always_ff @(posedge clk) begin
        if (reset) begin
            stray_beat <= 1'b0;
        end else if (avm_node_readdatavalid && !beat_take) begin
            stray_beat <= 1'b1;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        asi_addr_ready      = (state == ST_IDLE);
        avm_node_read       = (state == ST_REQ);
        avm_node_address    = addr;
        avm_node_burstcount = 6'(BURST_LEN);
        aso_node_valid      = (state == ST_OUT);
        aso_node_data       = node_word;
        busy                = (state != ST_IDLE);
    end

endmodule
